// File: rtl/bus_rr_sched_pkg.sv
// bus_sched_pkg: shared state encoding, address width, timeout and destination decode for bus_rr_sched.
package bus_sched_pkg;
  typedef enum logic [1:0] {IDLE, POP, DELIV} state_e;
  localparam int ADDR_W = 8;
  localparam int TIMEOUT = 1024;
  // Unicast wins over broadcast if the broadcast code is a valid agent index; an all-zero mask means drop.
  function automatic logic [31:0] dest_mask(input logic [ADDR_W-1:0] addr, input int src, input int n,
                                            input logic [ADDR_W-1:0] bc);
    dest_mask = '0;
    for (int i = 0; i < 32; i++)
      if (i < n && ((int'(addr) < n) ? i == int'(addr) : (addr == bc && i != src))) dest_mask[i] = 1'b1;
  endfunction
endpackage

// File: rtl/bus_rr_sched_rr_picker.sv
// rr_picker: combinational round-robin search over req, starting at ptr and wrapping.
module rr_picker #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt,
  output logic          vld
);
  logic [IW-1:0] idx;
  // Scan from the farthest offset down so the closest requester to ptr is written last.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt = idx;
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_rr_sched.sv
// bus_rr_sched: round-robin packet scheduler between agent FIFOs; BUS_RR_SCHED_TIMEOUT_EN adds a DELIV timeout and to_err.
module bus_rr_sched
  import bus_sched_pkg::*;
#(
  parameter int drvrs = 4,
  parameter int pckg_sz = 16,
  parameter logic [ADDR_W-1:0] broadcast = 8'hFF,
  localparam int IW = drvrs > 1 ? $clog2(drvrs) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  input  logic [drvrs-1:0]                full,
  output logic [drvrs-1:0]                push,
  output logic [pckg_sz-1:0]              D_push,
  output logic [IW-1:0]                   grant_id,
  output logic                            busy,
  output logic [7:0]                      drop_cnt
`ifdef BUS_RR_SCHED_TIMEOUT_EN
  , output logic                          to_err
`endif
);
  state_e               state_q;
  logic [IW-1:0]        grant_q, ptr_q, pick_id, ptr_nxt;
  logic                 pick_vld, drop_w, deliver, tmo;
  logic [pckg_sz-1:0]   pkt_q;
  logic [drvrs-1:0]     pop_q, dmask;
  logic [7:0]           drop_q;
  logic [31:0]          mask_w;

  rr_picker #(.N(drvrs)) u_pick (.req(pndng), .ptr(ptr_q), .gnt(pick_id), .vld(pick_vld));

  assign mask_w  = dest_mask(pkt_q[pckg_sz-1 -: ADDR_W], int'(grant_q), drvrs, broadcast);
  assign dmask   = mask_w[drvrs-1:0];
  assign drop_w  = state_q == DELIV && mask_w == '0;
  // Push is combinational on full so delivery happens the very cycle backpressure clears.
  assign deliver = state_q == DELIV && !drop_w && (dmask & full) == '0;
  assign push    = deliver ? dmask : '0;
  assign D_push  = deliver ? pkt_q : '0;
  assign ptr_nxt = IW'((int'(grant_q) + 1) % drvrs);
  assign pop      = pop_q;
  assign grant_id = grant_q;
  assign busy     = state_q != IDLE;
  assign drop_cnt = drop_q;

`ifdef BUS_RR_SCHED_TIMEOUT_EN
  logic [15:0] wait_q;
  logic        to_err_q;
  assign tmo    = state_q == DELIV && !drop_w && !deliver && wait_q == 16'(TIMEOUT - 1);
  assign to_err = to_err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q   <= '0;
      to_err_q <= 1'b0;
    end else begin
      wait_q   <= state_q == DELIV ? wait_q + 16'd1 : '0;
      to_err_q <= tmo;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pop_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      pkt_q   <= '0;
      drop_q  <= '0;
    end else begin
      pop_q <= '0;
      case (state_q)
        IDLE: if (pick_vld) begin
          grant_q <= pick_id;
          pop_q   <= drvrs'(1) << pick_id;
          state_q <= POP;
        end
        POP: begin
          pkt_q   <= D_pop[grant_q];
          state_q <= DELIV;
        end
        DELIV: if (drop_w || deliver || tmo) begin
          ptr_q   <= ptr_nxt;
          state_q <= IDLE;
          if (drop_w || tmo) drop_q <= drop_q + (drop_q != 8'hFF ? 8'd1 : 8'd0);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bus_rr_sched.md
Name: bus_rr_sched

Overview:
- Round-robin packet scheduler for the shared bus between `drvrs` agent FIFOs.
- Picks one pending source FIFO and pops its head packet {addr, payload}.
- Decodes the address and pushes the packet to one destination, or to all other agents on broadcast.
- Honours per-destination full backpressure; one packet in flight at a time.

Parameters:
- drvrs, 4, number of agents (source FIFOs and destination FIFOs).
- pckg_sz, 16, packet width in bits; packet = {addr[pckg_sz-1 -: 8], payload}.
- broadcast, 8'hFF, address value meaning "all agents except the source".

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- pndng  in  drvrs  per-source FIFO not-empty; head word is valid on D_pop while high (first-word fall-through).
- D_pop  in  drvrs x pckg_sz  per-source FIFO head data.
- pop  out  drvrs  one-hot, 1-cycle pop strobe to the granted source.
- full  in  drvrs  per-destination FIFO full.
- push  out  drvrs  push strobe mask to destinations, 1 cycle.
- D_push  out  pckg_sz  packet delivered; valid only while push != 0.
- grant_id  out  $clog2(drvrs)  source of the packet currently in flight.
- busy  out  1  high in POP and DELIV.
- drop_cnt  out  8  saturating count of dropped packets.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pop=0, push=0, D_push=0, grant_id=0, busy=0, drop_cnt=0, rr_ptr=0. An in-flight packet is discarded.
- State IDLE:
  - If |pndng, grant = first index i with pndng[i]=1, searching from rr_ptr upward and wrapping modulo drvrs.
  - Register grant_id; go to POP.
  - Else stay in IDLE.
- State POP (exactly 1 cycle):
  - pop[grant_id]=1.
  - pkt_reg <= D_pop[grant_id] on the same edge.
  - Go to DELIV.
- State DELIV: compute dest_mask from addr = pkt_reg[pckg_sz-1 -: 8]:
  - addr < drvrs: one-hot(addr). Self-addressed packets are legal and delivered.
  - addr == broadcast: all ones with bit grant_id cleared. For drvrs=1 this mask is zero; treat it as a drop.
  - Any other value: invalid. No push; drop_cnt +1 (saturating at 255); rr_ptr = grant_id+1 mod drvrs; go to IDLE.
  - If (dest_mask & full)==0: push=dest_mask and D_push=pkt_reg for 1 cycle; rr_ptr = grant_id+1 mod drvrs; go to IDLE.
  - Otherwise hold in DELIV with push=0. Broadcast is all-or-nothing: wait until every target is not full.
- Latency: pndng first seen in IDLE at cycle N → pop at N+1 → earliest push at N+2.
- Throughput: at most one packet per 3 cycles.
- pndng changes while in POP or DELIV are ignored.
- Only one pop per packet; no pop is issued while in DELIV.
- push and pop are never high in the same cycle.

Optional Feature:
- Macro: BUS_RR_SCHED_TIMEOUT_EN.
- When defined:
  - A 16-bit wait counter runs in DELIV and is cleared on entry.
  - If it reaches the TIMEOUT constant (default 1024), the packet is dropped: drop_cnt +1, rr_ptr advances, go to IDLE.
  - Output `to_err` (1 bit) pulses for 1 cycle on each timeout; it resets to 0.
- When undefined: DELIV waits indefinitely and the `to_err` port is absent.

Decomposition:
- Package bus_sched_pkg holds:
  - state enum {IDLE, POP, DELIV};
  - ADDR_W=8;
  - TIMEOUT constant;
  - function dest_mask(addr, src, drvrs, broadcast).
- Sub-module rr_picker: combinational priority search, rotated by rr_ptr, over pndng. Outputs grant index and a valid flag.

Test Plan (drvrs=4, pckg_sz=16):
- Single unicast: pndng=4'b0100, D_pop[2]=16'h01AB → pop=4'b0100 at N+1; push=4'b0010, D_push=16'h01AB at N+2.
- Fairness: pndng=4'b1111 held, all packets addressed to 0 → grant_id sequence 0,1,2,3,0, each pop 3 cycles apart.
- Broadcast from source 1, D_pop[1]=16'hFF55 → push=4'b1101, D_push=16'hFF55; bit 1 never set.
- Backpressure: packet 16'h0377 with full[3]=1 for 5 cycles → busy stays high, no push and no other pop during the wait; push=4'b1000 in the first cycle after full[3] falls.
- Invalid address 16'h0712 → no push, drop_cnt=1, next grant from source+1.
- Reset asserted in DELIV → next cycle all outputs 0, packet lost, next grant searches from index 0.
